// File: rtl/jam_pkg.sv
// Shared constants, FSM state type and address helper for the jam cost table.
//   N      : workers = jobs, matrix is N x N
//   IDX_W  : width of a W/J index
//   COST_W : width of one cost word
//   SUM_W  : width of the row-minimum sum
//   ADDR_W : width of a flat matrix address
package jam_pkg;
  localparam int N      = 8;
  localparam int IDX_W  = 3;
  localparam int COST_W = 7;
  localparam int SUM_W  = 10;
  localparam int ADDR_W = 2 * IDX_W;

  typedef enum logic {ST_LOAD, ST_READY} jam_state_e;

  // Flat row-major address of cost(w, j).
  function automatic logic [ADDR_W-1:0] idx(input logic [IDX_W-1:0] w,
                                            input logic [IDX_W-1:0] j);
    return ADDR_W'(w) * ADDR_W'(N) + ADDR_W'(j);
  endfunction
endpackage

// File: rtl/jam_cost_table_if.sv
// Valid/ready cost-word stream feeding the jam cost table.
//   in_valid : word valid (master -> slave)
//   in_ready : table accepting words (slave -> master)
//   in_data  : cost word, row-major order
interface jam_cost_table_if;
  import jam_pkg::*;
  logic              in_valid;
  logic              in_ready;
  logic [COST_W-1:0] in_data;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/jam_cost_table_row_min.sv
// Streaming row-minimum accumulator (built only with JAM_ROW_MIN_EN).
//   CLK, RST : clock, synchronous active-high reset
//   clr_i    : clear running state (reload)
//   en_i     : a word is being transferred this cycle
//   col_i    : column of the current word (cnt % N)
//   data_i   : current cost word
//   acc_d_o  : accumulator value after this cycle's word
module jam_row_min
  import jam_pkg::*;
(
  input  logic              CLK,
  input  logic              RST,
  input  logic              clr_i,
  input  logic              en_i,
  input  logic [IDX_W-1:0]  col_i,
  input  logic [COST_W-1:0] data_i,
  output logic [SUM_W-1:0]  acc_d_o
);
  logic [COST_W-1:0] rmin_q, rmin_d, cur_min;
  logic [SUM_W-1:0]  acc_q, acc_d;

  always_comb begin
    cur_min = (col_i == '0) ? data_i : ((data_i < rmin_q) ? data_i : rmin_q);
    rmin_d  = rmin_q;
    acc_d   = acc_q;
    if (en_i) begin
      rmin_d = cur_min;
      if (col_i == IDX_W'(N - 1))
        acc_d = acc_q + SUM_W'(cur_min);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST || clr_i) begin
      rmin_q <= '0;
      acc_q  <= '0;
    end else begin
      rmin_q <= rmin_d;
      acc_q  <= acc_d;
    end
  end

  assign acc_d_o = acc_d;
endmodule

// File: rtl/jam_cost_table.sv
// Cost-matrix loader and lookup table for the job-assignment search engine.
// Accepts N*N cost words over a valid/ready stream, holds the engine in reset
// until the matrix is complete, then freezes and serves combinational lookups.
//   CLK, RST    : clock, synchronous active-high reset
//   s           : cost-word stream (slave side)
//   reload      : pulse; discard table and restart loading
//   W, J        : lookup indices from the engine
//   Cost        : mem[W*N+J], zero latency
//   jam_rst     : engine reset, registered
//   load_done   : table complete and frozen
//   lower_bound : sum of per-row minima (JAM_ROW_MIN_EN), else 0
// Optional feature macro: JAM_ROW_MIN_EN
module jam_cost_table
  import jam_pkg::*;
(
  input  logic              CLK,
  input  logic              RST,
  jam_cost_table_if.slave   s,
  input  logic              reload,
  input  logic [IDX_W-1:0]  W,
  input  logic [IDX_W-1:0]  J,
  output logic [COST_W-1:0] Cost,
  output logic              jam_rst,
  output logic              load_done,
  output logic [SUM_W-1:0]  lower_bound
);
  logic [COST_W-1:0] mem [N*N];
  jam_state_e        state_q;
  logic [ADDR_W-1:0] cnt_q;
  logic              in_ready_q, jam_rst_q, load_done_q;
  logic              xfer, last;

  // in_ready_q is high exactly in ST_LOAD, so it qualifies the transfer alone.
  assign xfer = s.in_valid && in_ready_q;
  assign last = (cnt_q == ADDR_W'(N * N - 1));

`ifdef JAM_ROW_MIN_EN
  logic [SUM_W-1:0] acc_d;
  logic [SUM_W-1:0] lb_q;

  jam_row_min u_row_min (
    .CLK     (CLK),
    .RST     (RST),
    .clr_i   (reload),
    .en_i    (xfer),
    .col_i   (cnt_q[IDX_W-1:0]),
    .data_i  (s.in_data),
    .acc_d_o (acc_d)
  );

  always_ff @(posedge CLK) begin
    if (RST || reload)
      lb_q <= '0;
    else if (xfer && last)
      lb_q <= acc_d;
  end

  assign lower_bound = lb_q;
`else
  assign lower_bound = '0;
`endif

  always_ff @(posedge CLK) begin
    if (RST || reload) begin
      state_q     <= ST_LOAD;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      jam_rst_q   <= 1'b1;
      load_done_q <= 1'b0;
    end else begin
      case (state_q)
        ST_LOAD: begin
          if (xfer) begin
            if (last) begin
              state_q     <= ST_READY;
              cnt_q       <= '0;
              in_ready_q  <= 1'b0;
              jam_rst_q   <= 1'b0;
              load_done_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        ST_READY: ;
        default: begin
          state_q     <= ST_LOAD;
          cnt_q       <= '0;
          in_ready_q  <= 1'b1;
          jam_rst_q   <= 1'b1;
          load_done_q <= 1'b0;
        end
      endcase
    end
  end

  // Storage is never cleared; a word coinciding with reload or RST is dropped.
  always_ff @(posedge CLK) begin
    if (!RST && !reload && xfer)
      mem[cnt_q] <= s.in_data;
  end

  assign s.in_ready = in_ready_q;
  assign jam_rst    = jam_rst_q;
  assign load_done  = load_done_q;
  assign Cost       = mem[idx(W, J)];
endmodule
